// File: rtl/servo_pkg.sv
// rtl/servo_pkg.sv - shared constants, FSM state encoding and magnitude-to-ticks helper for the servo scheduler
package servo_pkg;

    localparam int CLK_HZ_DEF      = 50_000_000;
    localparam int FRAME_HZ_DEF    = 50;
    localparam int MIN_TICKS_DEF   = 50_000;
    localparam int SPAN_TICKS_DEF  = 50_000;
    localparam int STEP_DEF        = 16;
    localparam int FRAME_TICKS_DEF = CLK_HZ_DEF / FRAME_HZ_DEF;

    localparam logic [11:0] MAG_RESET = 12'd2048;

    typedef logic [1:0] servo_state_t;
    localparam servo_state_t ST_IDLE   = 2'd0;
    localparam servo_state_t ST_UPDATE = 2'd1;
    localparam servo_state_t ST_RUN    = 2'd2;

    // 12-bit magnitude times span fits 28 bits; the scaled result stays within 17 bits.
    function automatic logic [16:0] mag_to_ticks(input logic [11:0] mag,
                                                 input int unsigned min_t = MIN_TICKS_DEF,
                                                 input int unsigned span_t = SPAN_TICKS_DEF);
        logic [27:0] prod;
        prod = 28'(mag) * 28'(span_t);
        return 17'(min_t) + 17'(prod >> 12);
    endfunction

endpackage

// File: rtl/servo_chan.sv
// rtl/servo_chan.sv - one servo channel: target/current position, per-frame slew, latched width, pulse window
module servo_chan
    import servo_pkg::*;
#(
    parameter int CW         = 20,
    parameter int MIN_TICKS  = MIN_TICKS_DEF,
    parameter int SPAN_TICKS = SPAN_TICKS_DEF,
    parameter int STEP       = STEP_DEF,
    parameter int START      = 4
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          slew_i,
    input  logic          wr_i,
    input  logic [11:0]   wr_mag_i,
    input  logic          run_i,
    input  logic [CW-1:0] count_i,
    output logic          pulse_o,
    output logic          busy_o
);

    localparam logic [11:0] STEP12 = 12'(STEP);

    logic [11:0] target_q, target_d;
    logic [11:0] current_q, current_d;
    logic [16:0] width_q, width_d;
    logic        pulse_q, pulse_d;
    logic        busy_q, busy_d;
    logic [31:0] cnt32, start32, end32;

    always_comb begin
        target_d  = wr_i ? wr_mag_i : target_q;
        current_d = current_q;
        width_d   = width_q;
        if (slew_i) begin
            if (target_q > current_q) begin
                current_d = (target_q - current_q <= STEP12) ? target_q : current_q + STEP12;
            end else if (target_q < current_q) begin
                current_d = (current_q - target_q <= STEP12) ? target_q : current_q - STEP12;
            end
            width_d = mag_to_ticks(current_d, MIN_TICKS, SPAN_TICKS);
        end
        busy_d = (current_d != target_d);

        // Pulse occupies counts START..START+width-1, so the pin rises one cycle after count == START.
        cnt32   = 32'(count_i);
        start32 = 32'(START);
        end32   = start32 + {15'd0, width_q};
        pulse_d = run_i && (cnt32 >= start32) && (cnt32 < end32);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            target_q  <= MAG_RESET;
            current_q <= MAG_RESET;
            width_q   <= mag_to_ticks(MAG_RESET, MIN_TICKS, SPAN_TICKS);
            pulse_q   <= 1'b0;
            busy_q    <= 1'b0;
        end else begin
            target_q  <= target_d;
            current_q <= current_d;
            width_q   <= width_d;
            pulse_q   <= pulse_d;
            busy_q    <= busy_d;
        end
    end

    assign pulse_o = pulse_q;
    assign busy_o  = busy_q;

endmodule

// File: rtl/servo_slew_ctrl.sv
// rtl/servo_slew_ctrl.sv - multi-channel servo frame scheduler; define SERVO_STAGGER_EN to stagger channel pulses
module servo_slew_ctrl
    import servo_pkg::*;
#(
    parameter int CLK_HZ     = CLK_HZ_DEF,
    parameter int FRAME_HZ   = FRAME_HZ_DEF,
    parameter int NCH        = 4,
    parameter int MIN_TICKS  = MIN_TICKS_DEF,
    parameter int SPAN_TICKS = SPAN_TICKS_DEF,
    parameter int STEP       = STEP_DEF,
    localparam int CHW       = (NCH > 1) ? $clog2(NCH) : 1
) (
    input  logic           clk,
    input  logic           reset,
    input  logic           enable,
    input  logic           cmd_valid,
    output logic           cmd_ready,
    input  logic [CHW-1:0] cmd_ch,
    input  logic [11:0]    cmd_mag,
    output logic [NCH-1:0] pulse_out,
    output logic           frame_tick,
    output logic [NCH-1:0] busy
);

    localparam int FRAME_TICKS = CLK_HZ / FRAME_HZ;
    localparam int CW          = $clog2(FRAME_TICKS);

    if (NCH < 1 || NCH > 8) begin : g_bad_nch
        $error("servo_slew_ctrl: NCH must be 1..8");
    end
    if (NCH + NCH * (MIN_TICKS + SPAN_TICKS) >= FRAME_TICKS) begin : g_bad_frame
        $error("servo_slew_ctrl: channel pulse slots do not fit in one frame");
    end

    servo_state_t  state_q, state_d;
    logic [CW-1:0] count_q, count_d;
    logic          ready_q, tick_q, tick_d;
    logic          cmd_accept, updating, running;

    always_comb begin
        state_d = state_q;
        count_d = count_q;
        if (!enable) begin
            state_d = ST_IDLE;
            count_d = '0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    state_d = ST_UPDATE;
                    count_d = '0;
                end
                ST_UPDATE: begin
                    count_d = count_q + CW'(1);
                    if (count_q == CW'(NCH - 1)) state_d = ST_RUN;
                end
                ST_RUN: begin
                    if (count_q == CW'(FRAME_TICKS - 1)) begin
                        state_d = ST_UPDATE;
                        count_d = '0;
                    end else begin
                        count_d = count_q + CW'(1);
                    end
                end
                default: begin
                    state_d = ST_IDLE;
                    count_d = '0;
                end
            endcase
        end
        tick_d = enable && (state_q == ST_UPDATE) && (count_q == '0);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= ST_IDLE;
            count_q <= '0;
            ready_q <= 1'b0;
            tick_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            count_q <= count_d;
            ready_q <= (state_d != ST_UPDATE);
            tick_q  <= tick_d;
        end
    end

    assign cmd_ready  = ready_q;
    assign frame_tick = tick_q;
    assign cmd_accept = cmd_valid && ready_q;
    assign updating   = (state_q == ST_UPDATE);
    assign running    = enable && (state_q == ST_RUN);

    for (genvar i = 0; i < NCH; i++) begin : g_chan
`ifdef SERVO_STAGGER_EN
        localparam int OFF = i * (MIN_TICKS + SPAN_TICKS);
`else
        localparam int OFF = 0;
`endif
        servo_chan #(
            .CW         (CW),
            .MIN_TICKS  (MIN_TICKS),
            .SPAN_TICKS (SPAN_TICKS),
            .STEP       (STEP),
            .START      (NCH + OFF)
        ) u_chan (
            .clk      (clk),
            .reset    (reset),
            .slew_i   (updating && (count_q == CW'(i))),
            .wr_i     (cmd_accept && (cmd_ch == CHW'(i))),
            .wr_mag_i (cmd_mag),
            .run_i    (running),
            .count_i  (count_q),
            .pulse_o  (pulse_out[i]),
            .busy_o   (busy[i])
        );
    end

endmodule

// File: tb/tb_servo_slew_ctrl.sv
// tb/tb_servo_slew_ctrl.sv - scoreboard bench for servo_slew_ctrl with a frame-level reference model
module tb_servo_slew_ctrl;

    localparam int NCH      = 3;
    localparam int CLK_HZ   = 50_000;
    localparam int FRAME_HZ = 50;
    localparam int MIN_T    = 50;
    localparam int SPAN_T   = 50;
    localparam int STEP     = 256;
    localparam int FT       = CLK_HZ / FRAME_HZ;

    logic           clk = 1'b0;
    logic           reset = 1'b1;
    logic           enable = 1'b0;
    logic           cmd_valid = 1'b0;
    logic           cmd_ready;
    logic [1:0]     cmd_ch = 2'd0;
    logic [11:0]    cmd_mag = 12'd0;
    logic [NCH-1:0] pulse_out;
    logic           frame_tick;
    logic [NCH-1:0] busy;

    servo_slew_ctrl #(
        .CLK_HZ(CLK_HZ), .FRAME_HZ(FRAME_HZ), .NCH(NCH),
        .MIN_TICKS(MIN_T), .SPAN_TICKS(SPAN_T), .STEP(STEP)
    ) dut (
        .clk(clk), .reset(reset), .enable(enable),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_ch(cmd_ch), .cmd_mag(cmd_mag),
        .pulse_out(pulse_out), .frame_tick(frame_tick), .busy(busy)
    );

    always #5 clk = ~clk;

    int     n_cmp = 0;
    int     n_bad = 0;
    longint cyc = 0;
    int     m_tgt [NCH];
    int     m_cur [NCH];
    int     exp_q [NCH][$];
    longint rise_at [NCH];
    longint last_tick = 0;
    bit     have_tick = 0;
    bit     prev_p [NCH];
    bit     dis_prev = 0;
    bit     rst_prev = 0;
    bit     prev_ready = 0;

    function automatic int off_of(input int i);
`ifdef SERVO_STAGGER_EN
        return i * (MIN_T + SPAN_T);
`else
        return 0;
`endif
    endfunction

    function automatic int ticks_of(input int mag);
        return MIN_T + (mag * SPAN_T) / 4096;
    endfunction

    task automatic check(input string name, input longint act, input longint exp);
        n_cmp++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    initial forever begin
        @(posedge clk);
        cyc++;
    end

    // Monitor: frame model, pulse scoreboard, handshake and reset/disable observation.
    initial begin
        for (int i = 0; i < NCH; i++) begin
            m_tgt[i] = 2048;
            m_cur[i] = 2048;
            prev_p[i] = 0;
        end
        forever begin
            @(negedge clk);
            if (dis_prev) begin
                check("idle_pulse_out", pulse_out, 0);
                check("idle_frame_tick", frame_tick, 0);
                if (rst_prev) begin
                    check("reset_busy", busy, 0);
                    check("reset_cmd_ready", cmd_ready, 0);
                end
                have_tick = 0;
                for (int i = 0; i < NCH; i++) begin
                    exp_q[i].delete();
                    prev_p[i] = 0;
                end
            end else begin
                if (frame_tick) begin
                    if (have_tick) begin
                        check("frame_period", cyc - last_tick, FT);
                        for (int i = 0; i < NCH; i++) check("pulses_per_frame", exp_q[i].size(), 0);
                    end
                    check("ready_low_before_tick", prev_ready, 0);
                    for (int i = 0; i < NCH; i++) begin
                        int d;
                        exp_q[i].delete();
                        d = m_tgt[i] - m_cur[i];
                        if (d > STEP) d = STEP;
                        if (d < -STEP) d = -STEP;
                        m_cur[i] += d;
                        exp_q[i].push_back(ticks_of(m_cur[i]));
                    end
                    last_tick = cyc;
                    have_tick = 1;
                end
                if (have_tick) begin
                    longint rel;
                    rel = cyc - last_tick;
                    if (rel < NCH - 1) check("ready_low_in_update", cmd_ready, 0);
                    if (rel == NCH - 1) begin
                        logic [NCH-1:0] mb;
                        for (int i = 0; i < NCH; i++) mb[i] = (m_cur[i] != m_tgt[i]);
                        check("ready_high_in_run", cmd_ready, 1);
                        check("busy_after_slew", busy, mb);
                    end
                end
`ifdef SERVO_STAGGER_EN
                check("no_overlap", ($countones(pulse_out) <= 1), 1);
`endif
                for (int i = 0; i < NCH; i++) begin
                    if (pulse_out[i] && !prev_p[i]) rise_at[i] = cyc;
                    if (!pulse_out[i] && prev_p[i]) begin
                        if (!have_tick || exp_q[i].size() == 0) begin
                            n_cmp++;
                            n_bad++;
                            $display("FAIL pulse_unexpected: ch%0d width %0d, expected no pulse (cycle %0d)",
                                     i, cyc - rise_at[i], cyc);
                        end else begin
                            int w;
                            w = exp_q[i].pop_front();
                            check($sformatf("pulse_width_ch%0d", i), cyc - rise_at[i], w);
                            check($sformatf("pulse_start_ch%0d", i), rise_at[i] - last_tick, NCH + off_of(i));
                        end
                    end
                    prev_p[i] = pulse_out[i];
                end
            end
            if (reset) begin
                for (int i = 0; i < NCH; i++) begin
                    m_tgt[i] = 2048;
                    m_cur[i] = 2048;
                end
            end else if (cmd_valid && cmd_ready && cmd_ch < NCH) begin
                m_tgt[cmd_ch] = int'(cmd_mag);
            end
            prev_ready = cmd_ready;
            dis_prev   = reset || !enable;
            rst_prev   = reset;
        end
    end

    task automatic send_cmd(input int ch, input int mag);
        bit done;
        done      = 0;
        cmd_valid = 1'b1;
        cmd_ch    = ch[1:0];
        cmd_mag   = mag[11:0];
        for (int k = 0; k < 50 && !done; k++) begin
            @(negedge clk);
            if (cmd_ready) done = 1;
            @(posedge clk);
            #1;
        end
        cmd_valid = 1'b0;
        check("cmd_accepted", done, 1);
    endtask

    task automatic wait_ticks(input int n);
        int seen;
        int k;
        seen = 0;
        k = 0;
        while (seen < n && k < n * FT + 100) begin
            @(negedge clk);
            k++;
            if (frame_tick) seen++;
        end
        check("frame_ticks_seen", seen, n);
        @(posedge clk);
        #1;
    endtask

    task automatic wait_mid_pulse();
        int k;
        k = 0;
        while (pulse_out == '0 && k < 2 * FT) begin
            @(negedge clk);
            k++;
        end
        check("pulse_seen", (pulse_out != '0), 1);
        repeat (5) @(posedge clk);
        #1;
    endtask

    task automatic rand_cmd();
        int ch;
        int sel;
        int mag;
        ch  = $urandom_range(0, 3);
        sel = $urandom_range(0, 3);
        mag = (sel == 0) ? 0 : (sel == 1) ? 4095 : $urandom_range(0, 4095);
        send_cmd(ch, mag);
    endtask

    initial begin
        int k;
        bit found;
        reset  = 1'b1;
        enable = 1'b1;
        repeat (4) @(posedge clk);
        #1 reset = 1'b0;

        wait_ticks(3);

        send_cmd(1, 4095);
        wait_ticks(10);

        repeat (30) begin
            repeat ($urandom_range(0, 400)) @(posedge clk);
            #1;
            rand_cmd();
        end
        wait_ticks(4);

        repeat (2) begin
            wait_ticks(1);
            repeat (FT - 30) @(posedge clk);
            #1;
            repeat (40) rand_cmd();
        end
        wait_ticks(2);

        wait_mid_pulse();
        enable = 1'b0;
        send_cmd(2, 300);
        repeat (20) @(posedge clk);
        #1 enable = 1'b1;
        k = 0;
        found = 0;
        while (k < 8 && !found) begin
            @(negedge clk);
            k++;
            if (frame_tick) found = 1;
        end
        check("reenable_tick_latency", k, 3);
        @(posedge clk);
        #1;
        wait_ticks(4);

        send_cmd(0, 4095);
        wait_ticks(2);
        wait_mid_pulse();
        reset = 1'b1;
        repeat (3) @(posedge clk);
        #1 reset = 1'b0;
        wait_ticks(3);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #900_000;
        $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
        $fatal(1, "watchdog expired");
    end

endmodule
